adder_rr_sequencer: RTL and testbench

- Shares one instance of the team's 32-bit Kogge-Stone adder (n_bit_pg_Kogge_Stone_A) among NREQ requesters using round-robin arbitration.
- Supports multi-word chained additions. A requester holds the adder across beats, and each beat's carry-out feeds the next beat's carry-in.
- Results leave through a single registered response port with valid/ready backpressure.
- Sits between the ALU issue logic and the shared adder datapath.

---
 rtl/adder_rr_sequencer_pkg.sv | 22 ++
 rtl/adder_rr_sequencer_if.sv | 38 +++
 rtl/adder_rr_sequencer_rr_arbiter.sv | 38 +++
 rtl/n_bit_pg_Kogge_Stone_A.sv | 46 ++++
 rtl/adder_rr_sequencer.sv | 148 ++++++++++++++
 tb/tb_adder_rr_sequencer.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_rr_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_seq_pkg: shared types and defaults for adder_rr_sequencer.
// Rev 1.0
// ------------------------------------------------------------------
package adder_seq_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;
  localparam int BW_DEF   = 3;

  function automatic int idw_f(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_rr_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_rr_sequencer_if: requester and response bundle.
// Rev 1.0
// ------------------------------------------------------------------
interface adder_rr_sequencer_if
  import adder_seq_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw_f(NREQ),
  parameter int BW   = BW_DEF
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_last;
  logic [BW-1:0]     rsp_beat;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, rsp_beat
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, rsp_beat
  );
endinterface
`default_nettype wire

// File: rtl/adder_rr_sequencer_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick starting at ptr.
// Rev 1.0
// ------------------------------------------------------------------
module rr_arbiter
  import adder_seq_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw_f(NREQ)
) (
  input  wire logic [NREQ-1:0] req,
  input  wire logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0]      grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 grant_any
);
  always_comb begin
    int cand;
    logic [IDW-1:0] cand_id;
    cand      = 0;
    cand_id   = '0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = IDW'(cand);
      if (!grant_any && req[cand_id]) begin
        grant[cand_id] = 1'b1;
        grant_id       = cand_id;
        grant_any      = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/n_bit_pg_Kogge_Stone_A.sv
`default_nettype none
// ------------------------------------------------------------------
// n_bit_pg_Kogge_Stone_A: parallel-prefix adder with carry in/out.
// Rev 1.0
// ------------------------------------------------------------------
module n_bit_pg_Kogge_Stone_A #(
  parameter int N = 32
) (
  input  wire logic [N-1:0] a,
  input  wire logic [N-1:0] b,
  input  wire logic         cin,
  output wire logic [N-1:0] sum,
  output wire logic         cout
);
  localparam int L = $clog2(N);

  wire [N-1:0] gen_lvl [0:L];
  wire [N-1:0] prp_lvl [0:L-1];
  wire [N-1:0] p0;

  assign p0 = a ^ b;
  // cin is folded into bit 0 so every prefix G[i:0] is already the carry into bit i+1
  assign gen_lvl[0] = (a & b) | {{(N-1){1'b0}}, p0[0] & cin};
  assign prp_lvl[0] = p0;

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign gen_lvl[l+1][i] = gen_lvl[l][i] | (prp_lvl[l][i] & gen_lvl[l][i-D]);
        if (l + 1 < L) begin : g_prp
          assign prp_lvl[l+1][i] = prp_lvl[l][i] & prp_lvl[l][i-D];
        end
      end else begin : g_pass
        assign gen_lvl[l+1][i] = gen_lvl[l][i];
        if (l + 1 < L) begin : g_prp
          assign prp_lvl[l+1][i] = prp_lvl[l][i];
        end
      end
    end
  end

  assign sum  = p0 ^ {gen_lvl[L][N-2:0], cin};
  assign cout = gen_lvl[L][N-1];
endmodule
`default_nettype wire

// File: rtl/adder_rr_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_rr_sequencer: round-robin sharing of one adder with chaining.
// Rev 1.0
// ------------------------------------------------------------------
module adder_rr_sequencer
  import adder_seq_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw_f(NREQ),
  parameter int BW   = BW_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  adder_rr_sequencer_if.slave   bus
);
  state_e           state_q, state_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             carry_q, carry_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0]     rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_last_q, rsp_last_d;
  logic [BW-1:0]    rsp_beat_q, rsp_beat_d;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;
  logic             acc_en;
  logic [NREQ-1:0]  ready_vec;
  logic             hs;
  logic [IDW-1:0]   sel_id;
  logic [N-1:0]     op_a, op_b;
  logic             add_cin;
  logic [N-1:0]     add_sum;
  logic             add_cout;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_id  (arb_id),
    .grant_any (arb_any)
  );

  always_comb begin
    acc_en    = !rsp_valid_q || bus.rsp_ready;
    ready_vec = '0;
    if (state_q == LOCKED) begin
      sel_id               = lock_id_q;
      ready_vec[lock_id_q] = acc_en;
      add_cin              = carry_q;
    end else begin
      sel_id    = arb_id;
      ready_vec = arb_any ? (arb_grant & {NREQ{acc_en}}) : '0;
      add_cin   = bus.req_cin[arb_id];
    end
    // ready must read 0 while reset is held, not only once the flops settle
    if (!rst_n) ready_vec = '0;
    hs   = |(ready_vec & bus.req_valid);
    op_a = bus.req_a[int'(sel_id)*N +: N];
    op_b = bus.req_b[int'(sel_id)*N +: N];
  end

  n_bit_pg_Kogge_Stone_A #(.N(N)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    carry_d     = carry_q;
    beat_d      = beat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_last_d  = rsp_last_q;
    rsp_beat_d  = rsp_beat_q;
    if (hs) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = sel_id;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_last_d  = bus.req_last[sel_id];
      rsp_beat_d  = beat_q;
      if (!bus.req_last[sel_id]) begin
        state_d   = LOCKED;
        lock_id_d = sel_id;
        carry_d   = add_cout;
        beat_d    = (beat_q == {BW{1'b1}}) ? beat_q : beat_q + 1'b1;
      end else begin
        state_d  = IDLE;
        carry_d  = 1'b0;
        beat_d   = '0;
        rr_ptr_d = (sel_id == IDW'(NREQ-1)) ? '0 : sel_id + 1'b1;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      carry_q     <= 1'b0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      carry_q     <= carry_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_last_q  <= rsp_last_d;
      rsp_beat_q  <= rsp_beat_d;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_beat  = rsp_beat_q;
endmodule
`default_nettype wire

// File: tb/tb_adder_rr_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_adder_rr_sequencer: directed plus random checks against a reference model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_adder_rr_sequencer;
  import adder_seq_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int BW   = 3;
  localparam int BMAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_rr_sequencer_if #(.N(N), .NREQ(NREQ), .IDW(IDW), .BW(BW)) bus ();

  adder_rr_sequencer #(.N(N), .NREQ(NREQ), .IDW(IDW), .BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NREQ-1:0] v    = '0;
  logic [NREQ-1:0] cin  = '0;
  logic [NREQ-1:0] last = '0;
  logic            rr   = 1'b1;
  logic [N-1:0]    a [NREQ];
  logic [N-1:0]    b [NREQ];

  always_comb begin
    bus.req_valid = v;
    bus.req_cin   = cin;
    bus.req_last  = last;
    bus.rsp_ready = rr;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*N +: N] = a[i];
      bus.req_b[i*N +: N] = b[i];
    end
  end

  // reference model: chain ownership, carry, beat count, rr pointer and expected response
  bit          m_locked;
  int          m_owner, m_ptr, m_beat;
  logic        m_carry;
  bit          e_valid;
  int          e_id, e_beat;
  logic [N-1:0] e_sum;
  logic        e_cout, e_last;
  int          hs_id = -1;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_beat = 0; m_carry = 1'b0;
    e_valid = 0; hs_id = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v = '0; cin = '0; last = '0; rr = 1'b1;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_sum",   bus.rsp_sum, 0);
    chk("rst_rsp_misc",  {bus.rsp_id, bus.rsp_cout, bus.rsp_last, bus.rsp_beat}, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] aa, input logic [N-1:0] bb,
                        input logic c, input logic l);
    v[i] = 1'b1; a[i] = aa; b[i] = bb; cin[i] = c; last[i] = l;
  endtask

  task automatic retire();
    if (hs_id >= 0) v[hs_id] = 1'b0;
  endtask

  // one clock: entered at a negedge with inputs already applied, returns at the next negedge
  task automatic cycle();
    logic [NREQ-1:0] er;
    logic [N:0]      s;
    int              w;
    bit              acc, h;
    #1;
    acc = !e_valid || rr;
    er  = '0;
    w   = -1;
    if (m_locked) w = m_owner;
    else begin
      for (int o = 0; o < NREQ; o++) begin
        int c;
        c = (m_ptr + o) % NREQ;
        if (w < 0 && v[c]) w = c;
      end
    end
    if (w >= 0 && acc) er[w] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    h = (w >= 0) && acc && v[w];
    hs_id = h ? w : -1;
    @(posedge clk);
    if (h) begin
      s = {1'b0, a[w]} + {1'b0, b[w]} + (N+1)'(m_locked ? m_carry : cin[w]);
      e_valid = 1; e_id = w; e_sum = s[N-1:0]; e_cout = s[N];
      e_last = last[w]; e_beat = m_beat;
      if (!last[w]) begin
        m_locked = 1; m_owner = w; m_carry = s[N];
        m_beat = (m_beat == BMAX) ? BMAX : m_beat + 1;
      end else begin
        m_locked = 0; m_carry = 1'b0; m_beat = 0; m_ptr = (w + 1) % NREQ;
      end
    end else if (rr) begin
      e_valid = 0;
    end
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, e_valid);
    if (e_valid) begin
      chk("rsp_id",   bus.rsp_id,   e_id);
      chk("rsp_sum",  bus.rsp_sum,  e_sum);
      chk("rsp_cout", bus.rsp_cout, e_cout);
      chk("rsp_last", bus.rsp_last, e_last);
      chk("rsp_beat", bus.rsp_beat, e_beat);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    case ($urandom % 4)
      0:       return '1;
      1:       return '0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = '0; end
    do_reset();

    // single ops on req0 and req2
    set_op(0, 32'd7, 32'd23, 1'b0, 1'b1); cycle(); retire();
    chk("tp1_sum", bus.rsp_sum, 32'd30);
    chk("tp1_fields", {bus.rsp_cout, bus.rsp_id, bus.rsp_last, bus.rsp_beat}, {1'b0, 2'd0, 1'b1, 3'd0});
    set_op(2, 32'h0, 32'hFFFF_FFF6, 1'b1, 1'b1); cycle(); retire();
    chk("tp2_sum", bus.rsp_sum, 32'hFFFF_FFF7);
    chk("tp2_cout", bus.rsp_cout, 0);

    // 64-bit chain on req1
    set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); cycle();
    chk("ch_b0", {bus.rsp_cout, bus.rsp_sum, bus.rsp_beat}, {1'b1, 32'h0, 3'd0});
    set_op(1, 32'h0, 32'h0, 1'b0, 1'b1); cycle(); retire();
    chk("ch_b1", {bus.rsp_cout, bus.rsp_sum, bus.rsp_beat}, {1'b0, 32'h1, 3'd1});

    // all four valid after reset: responses in ID order on consecutive cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i), 32'd100, 1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) begin
      cycle(); retire();
      chk("rr_order_id", bus.rsp_id, i);
      chk("rr_order_valid", bus.rsp_valid, 1);
    end

    // req0 3-beat chain while req3 waits; req0 drops valid mid-chain
    set_op(0, 32'd10, 32'd20, 1'b0, 1'b0);
    set_op(3, 32'd1, 32'd2, 1'b0, 1'b1);
    cycle();
    chk("lock_b0_id", bus.rsp_id, 0);
    v[0] = 1'b0; cycle();
    chk("lock_hold_r3", bus.req_ready[3], 0);
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0); cycle();
    set_op(0, 32'h0, 32'h0, 1'b0, 1'b1); cycle(); v[0] = 1'b0;
    chk("lock_b2", {bus.rsp_sum, bus.rsp_beat, bus.rsp_last}, {32'h1, 3'd2, 1'b1});
    cycle(); retire();
    chk("lock_r3_after", {bus.rsp_id, bus.rsp_sum}, {2'd3, 32'd3});

    // backpressure: pending response must hold and block all grants
    set_op(1, 32'd100, 32'd200, 1'b0, 1'b1); cycle(); retire();
    rr = 1'b0;
    set_op(2, 32'd5, 32'd5, 1'b0, 1'b1);
    repeat (3) begin
      cycle();
      chk("bp_sum", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum}, {1'b1, 2'd1, 32'd300});
      chk("bp_ready", bus.req_ready, 0);
    end
    rr = 1'b1; cycle(); retire();
    chk("bp_release", {bus.rsp_id, bus.rsp_sum}, {2'd2, 32'd10});

    // long chain: beat index saturates
    for (int k = 0; k < 10; k++) begin
      set_op(2, 32'(k), 32'd1, 1'b0, k == 9);
      cycle();
    end
    retire();
    chk("sat_beat", bus.rsp_beat, BMAX);

    // reset in the middle of a chain
    set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); cycle();
    chk("mid_b0_cout", bus.rsp_cout, 1);
    do_reset();
    set_op(3, 32'd1, 32'd1, 1'b0, 1'b1);
    set_op(2, 32'd5, 32'd6, 1'b0, 1'b1);
    cycle(); retire();
    chk("mid_ptr0", {bus.rsp_id, bus.rsp_sum}, {2'd2, 32'd11});
    cycle(); retire();
    chk("mid_nocarry", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout}, {2'd3, 32'd2, 1'b0});

    // randomized traffic with backpressure
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || hs_id == i) begin
          v[i]    = ($urandom % 3) != 0;
          a[i]    = rnd_word();
          b[i]    = rnd_word();
          cin[i]  = 1'($urandom % 2);
          last[i] = ($urandom % 5) == 0;
        end
      end
      rr = ($urandom % 4) != 0;
      cycle();
    end
    v = '0; rr = 1'b1;
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
